block_fetch_engine: RTL and testbench
=====================================

# block_fetch_engine

Parametrised successor to the free-running 8x8 block reader. It fetches a run of square pixel blocks from a synchronous-read sample memory through a single read port, assembles each into a BLK_DIM x BLK_DIM register array, and presents each block to the DCT stage over a valid/ready handshake. It adds a start/done command interface, block-linear and raster addressing modes, and backpressure. It sits between the frame sample memory and the DCT/quantiser pipeline.

## Interface
- DATA_W, 32, pixel word width
- ADDR_W, 12, memory address width
- BLK_DIM, 8, block edge in pixels (N = BLK_DIM*BLK_DIM words per block)
- CNT_W, 16, width of block count and line stride
- clock  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  command pulse; ignored while busy
- mode  in  1  0 = block-linear, 1 = raster; sampled on accepted start
- base_addr  in  ADDR_W  first word of block 0; sampled on start
- num_blocks  in  CNT_W  blocks to fetch; sampled on start
- line_stride  in  CNT_W  words per raster line (mode 1 only); sampled on start
- mem_rd_en  out  1  read strobe
- mem_addr  out  ADDR_W  read address
- mem_rd_data  in  DATA_W  read data, valid one cycle after mem_rd_en
- output_valid  out  1  block array holds a complete block
- output_ready  in  1  consumer accepts the block
- output_data_array  out  DATA_W x [BLK_DIM][BLK_DIM]  block, [row][col]
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the run completes

## Operation
- FSM states: IDLE, FETCH, DRAIN, HOLD.
- IDLE: `start` with `num_blocks` > 0 latches the command and goes to FETCH. `start` with `num_blocks` = 0 pulses `done` on the next cycle, issues no reads and leaves `busy` low.
- FETCH: issues one read per cycle, row-major within the block (r, c), N reads. Goes to DRAIN after the last issue.
- DRAIN: captures the last returned word, asserts `output_valid` and goes to HOLD.
- Address for block b, row r, column c:
  - mode 0: base + b*N + r*BLK_DIM + c
  - mode 1: base + r*line_stride + b*BLK_DIM + c
  - All arithmetic is modulo 2^ADDR_W; addresses wrap silently.
- Capture: data returned for (r, c) is written to `output_data_array[r][c]`, one cycle after its issue.
- HOLD:
  - The array and `output_valid` stay stable while `output_ready` is low.
  - On `output_valid & output_ready`, if blocks remain, go to FETCH for b+1 on the next cycle.
  - Otherwise go to IDLE, pulse `done` and drop `busy`.
- `output_valid` and `output_ready` high on the same edge as the last handshake: `done` pulses in the following cycle.
- There is a single buffer, so no fetch overlaps HOLD.

## Timing
- Reset values: `output_valid` 0, `busy` 0, `done` 0, `mem_rd_en` 0, `mem_addr` 0, every array element 0, state IDLE.
- Reset asserted mid-run aborts immediately: all outputs take reset values and the remaining blocks are discarded.
- Start latency: the edge accepting `start` registers the first address with `mem_rd_en` = 1. Reads issue on edges 0..N-1 and data is captured on edges 2..N+1. `output_valid` rises at edge N+1, i.e. 65 cycles for BLK_DIM = 8.
- Block-to-block: the next block's first read is registered on the edge that completes the handshake. The next `output_valid` follows N+1 edges later.
- `mem_rd_en` is low in IDLE, DRAIN and HOLD.

## Structure
- Shared package `fetch_pkg`: state enum, mode enum (MODE_BLOCK, MODE_RASTER), default parameter constants.
- Sub-module `fetch_addr_gen`: registered (b, r, c) counters plus address computation for both modes. It exposes `step`, `last_in_block` and `last_block`.
- Top level: FSM, capture write-enable pipeline (registered r, c, valid), array, handshake.

## Test plan
- Mode 0, base 0, num_blocks 2, memory word[i] = i, ready held high: arrays [0][0]=0, [7][7]=63, then [0][0]=64, [7][7]=127. First valid at cycle 65; a single `done` pulse.
- Mode 1, base 16, stride 64, num_blocks 1: [r][c] = 16 + 64r + c, so [7][7] = 471.
- Backpressure: ready low for 20 cycles after valid. Array and valid are stable; no `mem_rd_en` during HOLD; the next fetch starts on the handshake edge.
- Wrap: ADDR_W = 12, base 4090, mode 0, one block. Addresses 4090..4095 then 0..57; [0][6] equals word 0.
- `num_blocks` = 0: `done` pulses one cycle later with zero reads. `start` while busy is ignored and the read sequence is unchanged.
- `reset_n` low at cycle 30 of a fetch: all outputs return to reset values asynchronously; a new start after release fetches block 0 correctly.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the block fetch engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 12;
    localparam int DEF_BLK_DIM = 8;
    localparam int DEF_CNT_W   = 16;

    // Controller states, kept as plain constants so the state register
    // stays a bare vector in older netlists and waveform setups.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    typedef enum logic {
        MODE_BLOCK  = 1'b0,
        MODE_RASTER = 1'b1
    } mode_e;

    // Width of a row/column index; a 1x1 block still needs one bit.
    function automatic int idx_w(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

endpackage

// File: rtl/fetch_addr_gen.sv
// Block/row/column counters and read-address generator for one fetch run.
// Latency: addr/row/col are registered; they update on the edge after load/step.
// Backpressure: none internally; the caller withholds step to stall.
//
// Ports: load latches the command and points at (b0, r0, c0); step advances
// to the next word (or to the next block's first word when last_in_block).
// addr is the read address of the current position; last_block flags the
// final block of the run.
module fetch_addr_gen import fetch_pkg::*; #(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int BLK_DIM = DEF_BLK_DIM,
    parameter int CNT_W   = DEF_CNT_W,
    localparam int RC_W   = idx_w(BLK_DIM)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic              step,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  count,
    input  logic [CNT_W-1:0]  stride,
    output logic [ADDR_W-1:0] addr,
    output logic [RC_W-1:0]   row,
    output logic [RC_W-1:0]   col,
    output logic              last_in_block,
    output logic              last_block
);

    localparam logic [RC_W-1:0] IDX_LAST = RC_W'(BLK_DIM - 1);

    logic [ADDR_W-1:0] stride_lo;
    logic [ADDR_W-1:0] base_q, stride_q, addr_q;
    logic [ADDR_W-1:0] row_off_q, blk_off_q, row_off_n, blk_off_n;
    logic [ADDR_W-1:0] row_step, blk_step;
    logic [CNT_W-1:0]  blk_q, num_q, blk_n;
    logic [RC_W-1:0]   row_q, col_q, row_n, col_n;
    mode_e             mode_q;

    // Addresses are modulo 2^ADDR_W, so stride bits above ADDR_W never matter.
    if (CNT_W > ADDR_W) begin : g_stride_trunc
        logic stride_hi_unused;
        assign stride_hi_unused = ^stride[CNT_W-1:ADDR_W];
        assign stride_lo        = stride[ADDR_W-1:0];
    end else begin : g_stride_ext
        assign stride_lo = ADDR_W'(stride);
    end

    // Running offsets replace the b*N / r*stride multiplies: each step adds
    // a per-mode increment to the row or block offset.
    always_comb begin
        row_step  = (mode_q == MODE_RASTER) ? stride_q : ADDR_W'(BLK_DIM);
        blk_step  = (mode_q == MODE_RASTER) ? ADDR_W'(BLK_DIM) : ADDR_W'(BLK_DIM * BLK_DIM);
        blk_n     = blk_q;
        row_n     = row_q;
        col_n     = col_q;
        row_off_n = row_off_q;
        blk_off_n = blk_off_q;
        if (last_in_block) begin
            blk_n     = blk_q + CNT_W'(1);
            row_n     = '0;
            col_n     = '0;
            row_off_n = '0;
            blk_off_n = blk_off_q + blk_step;
        end else if (col_q == IDX_LAST) begin
            col_n     = '0;
            row_n     = row_q + RC_W'(1);
            row_off_n = row_off_q + row_step;
        end else begin
            col_n = col_q + RC_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            base_q    <= '0;
            stride_q  <= '0;
            addr_q    <= '0;
            row_off_q <= '0;
            blk_off_q <= '0;
            blk_q     <= '0;
            num_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            mode_q    <= MODE_BLOCK;
        end else if (load) begin
            base_q    <= base;
            stride_q  <= stride_lo;
            mode_q    <= mode_e'(mode);
            num_q     <= count;
            addr_q    <= base;
            row_off_q <= '0;
            blk_off_q <= '0;
            blk_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
        end else if (step) begin
            addr_q    <= base_q + blk_off_n + row_off_n + ADDR_W'(col_n);
            row_off_q <= row_off_n;
            blk_off_q <= blk_off_n;
            blk_q     <= blk_n;
            row_q     <= row_n;
            col_q     <= col_n;
        end
    end

    assign addr          = addr_q;
    assign row           = row_q;
    assign col           = col_q;
    assign last_in_block = (row_q == IDX_LAST) && (col_q == IDX_LAST);
    assign last_block    = (blk_q == num_q - CNT_W'(1));

endmodule

// File: rtl/block_fetch_engine.sv
// Fetches a run of BLK_DIM x BLK_DIM blocks from sync-read memory into a block array.
// Latency: first read on the start edge, output_valid N+1 edges later (N = BLK_DIM^2).
// Backpressure: single buffer; block and output_valid hold until output_ready, no reads meanwhile.
//
// Ports: start/mode/base_addr/num_blocks/line_stride form the command, sampled
// when start is accepted in idle. mem_rd_en/mem_addr/mem_rd_data is the read
// port (data one cycle after the strobe). output_valid/output_ready hand the
// block array [row][col] to the consumer. busy spans the run; done pulses once.
module block_fetch_engine import fetch_pkg::*; #(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int BLK_DIM = DEF_BLK_DIM,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_blocks,
    input  logic [CNT_W-1:0]  line_stride,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              output_valid,
    input  logic              output_ready,
    output logic [DATA_W-1:0] output_data_array [BLK_DIM][BLK_DIM],
    output logic              busy,
    output logic              done
);

    localparam int RC_W = idx_w(BLK_DIM);

    logic [1:0]      state;
    logic            load, step, handshake;
    logic            last_in_block, last_block;
    logic [RC_W-1:0] gen_row, gen_col;
    logic            cap_vld;
    logic [RC_W-1:0] cap_row, cap_col;

    assign handshake = output_valid && output_ready;
    assign load      = (state == ST_IDLE) && start && (num_blocks != '0);
    // Step within a block while fetching; on the handshake of a non-final
    // block the generator rolls over to the next block's first word.
    assign step      = ((state == ST_FETCH) && !last_in_block) ||
                       ((state == ST_HOLD) && handshake && !last_block);

    fetch_addr_gen #(
        .ADDR_W  (ADDR_W),
        .BLK_DIM (BLK_DIM),
        .CNT_W   (CNT_W)
    ) u_addr_gen (
        .clock         (clock),
        .reset_n       (reset_n),
        .load          (load),
        .step          (step),
        .mode          (mode),
        .base          (base_addr),
        .count         (num_blocks),
        .stride        (line_stride),
        .addr          (mem_addr),
        .row           (gen_row),
        .col           (gen_col),
        .last_in_block (last_in_block),
        .last_block    (last_block)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            mem_rd_en    <= 1'b0;
            output_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (num_blocks != '0) begin
                            state     <= ST_FETCH;
                            mem_rd_en <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    // The generator points at the read issued last edge; once
                    // that was the block's final word, stop strobing.
                    if (last_in_block) begin
                        state     <= ST_DRAIN;
                        mem_rd_en <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // The last word is captured on this edge by the pipeline.
                    state        <= ST_HOLD;
                    output_valid <= 1'b1;
                end
                ST_HOLD: begin
                    if (handshake) begin
                        output_valid <= 1'b0;
                        if (last_block) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= ST_FETCH;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // One stage carries (row, col) of each issued read to line up with the
    // memory's one-cycle read latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cap_vld <= 1'b0;
            cap_row <= '0;
            cap_col <= '0;
        end else begin
            cap_vld <= mem_rd_en;
            cap_row <= gen_row;
            cap_col <= gen_col;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < BLK_DIM; r++) begin
                for (int c = 0; c < BLK_DIM; c++) begin
                    output_data_array[r][c] <= '0;
                end
            end
        end else if (cap_vld) begin
            output_data_array[cap_row][cap_col] <= mem_rd_data;
        end
    end

endmodule

// File: tb/tb_block_fetch_engine.sv
// Self-checking bench for block_fetch_engine against an address/data reference model.
// Latency: expects output_valid N+1 edges after each block's first read.
// Backpressure: drives randomized output_ready stalls and checks hold stability.
module tb_block_fetch_engine;

    localparam int D     = 8;
    localparam int N     = D * D;
    localparam int AW    = 12;
    localparam int MEMSZ = 1 << AW;

    logic          clock;
    logic          reset_n;
    logic          start;
    logic          mode;
    logic [AW-1:0] base_addr;
    logic [15:0]   num_blocks;
    logic [15:0]   line_stride;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rd_data;
    logic          output_valid;
    logic          output_ready;
    logic [31:0]   arr [D][D];
    logic          busy;
    logic          done;

    logic [31:0]   mem [MEMSZ];
    logic [AW-1:0] rd_log [$];
    int            done_cnt;
    int            n_checks;
    int            n_errors;

    block_fetch_engine #(
        .DATA_W  (32),
        .ADDR_W  (AW),
        .BLK_DIM (D),
        .CNT_W   (16)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .start             (start),
        .mode              (mode),
        .base_addr         (base_addr),
        .num_blocks        (num_blocks),
        .line_stride       (line_stride),
        .mem_rd_en         (mem_rd_en),
        .mem_addr          (mem_addr),
        .mem_rd_data       (mem_rd_data),
        .output_valid      (output_valid),
        .output_ready      (output_ready),
        .output_data_array (arr),
        .busy              (busy),
        .done              (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read sample memory.
    always @(posedge clock) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    always @(negedge clock) begin
        if (mem_rd_en) rd_log.push_back(mem_addr);
        if (done) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference address of word (r, c) of block b.
    function automatic int exp_addr(input int m, input int base, input int stride,
                                    input int b, input int r, input int c);
        int a;
        if (m == 0) a = base + b * N + r * D + c;
        else        a = base + r * stride + b * D + c;
        return a & (MEMSZ - 1);
    endfunction

    task automatic fill_identity();
        for (int i = 0; i < MEMSZ; i++) mem[i] = i;
    endtask

    task automatic fill_random();
        for (int i = 0; i < MEMSZ; i++) mem[i] = $urandom;
    endtask

    task automatic run_cmd(input int m, input int base, input int nblk, input int stride,
                           input int stall_lo, input int stall_hi, input bit poke);
        int n, stall, bad, mism, d0, nrd;
        logic [31:0] snap [D][D];
        rd_log.delete();
        d0          = done_cnt;
        start       = 1'b1;
        mode        = m[0];
        base_addr   = base[AW-1:0];
        num_blocks  = nblk[15:0];
        line_stride = stride[15:0];
        @(posedge clock); #1;
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);
        check_eq("first_rd_en", mem_rd_en, 1);
        check_eq("first_addr", mem_addr, exp_addr(m, base, stride, 0, 0, 0));
        for (int b = 0; b < nblk; b++) begin
            n = 0;
            while (!output_valid && n < 300) begin
                // A start mid-fetch must not disturb the run.
                if (poke && b == 0 && n == 10) begin
                    start      = 1'b1;
                    mode       = ~mode;
                    base_addr  = base_addr + 12'd100;
                    num_blocks = 16'd5;
                end else begin
                    start = 1'b0;
                end
                @(posedge clock); #1;
                n++;
            end
            start = 1'b0;
            check_eq("valid_latency", n, N + 1);
            mism = 0;
            for (int r = 0; r < D; r++)
                for (int c = 0; c < D; c++)
                    if (arr[r][c] !== mem[exp_addr(m, base, stride, b, r, c)]) mism++;
            check_eq("blk_data_mismatches", mism, 0);
            check_eq("blk_last_word", arr[D-1][D-1], mem[exp_addr(m, base, stride, b, D-1, D-1)]);
            for (int r = 0; r < D; r++)
                for (int c = 0; c < D; c++)
                    snap[r][c] = arr[r][c];
            stall = $urandom_range(stall_hi, stall_lo);
            bad   = 0;
            repeat (stall) begin
                @(posedge clock); #1;
                if (output_valid !== 1'b1 || mem_rd_en !== 1'b0 || busy !== 1'b1) bad++;
                for (int r = 0; r < D; r++)
                    for (int c = 0; c < D; c++)
                        if (arr[r][c] !== snap[r][c]) bad++;
            end
            check_eq("hold_stable", bad, 0);
            output_ready = 1'b1;
            @(posedge clock); #1;
            output_ready = 1'b0;
            check_eq("valid_drop", output_valid, 0);
            if (b < nblk - 1) begin
                check_eq("next_rd_en", mem_rd_en, 1);
                check_eq("next_addr", mem_addr, exp_addr(m, base, stride, b + 1, 0, 0));
            end else begin
                check_eq("done_pulse", done, 1);
                check_eq("busy_drop", busy, 0);
                @(posedge clock); #1;
                check_eq("done_clear", done, 0);
            end
        end
        check_eq("done_count", done_cnt - d0, 1);
        check_eq("rd_count", rd_log.size(), nblk * N);
        nrd  = (rd_log.size() < nblk * N) ? rd_log.size() : nblk * N;
        mism = 0;
        for (int i = 0; i < nrd; i++)
            if (rd_log[i] !== AW'(exp_addr(m, base, stride, i / N, (i % N) / D, i % D))) mism++;
        check_eq("rd_addr_mismatches", mism, 0);
    endtask

    initial begin
        int nz, ok;
        n_checks     = 0;
        n_errors     = 0;
        done_cnt     = 0;
        reset_n      = 1'b1;
        start        = 1'b0;
        mode         = 1'b0;
        base_addr    = '0;
        num_blocks   = '0;
        line_stride  = '0;
        output_ready = 1'b0;
        mem_rd_data  = '0;
        fill_identity();

        // Reset state.
        #3 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_valid", output_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_rd_en", mem_rd_en, 0);
        check_eq("rst_addr", mem_addr, 0);
        nz = 0;
        for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++)
                if (arr[r][c] !== 32'd0) nz++;
        check_eq("rst_array_nonzero", nz, 0);
        @(negedge clock) reset_n = 1'b1;
        @(negedge clock);

        // Abort by reset at cycle 30 of a fetch.
        start       = 1'b1;
        mode        = 1'b0;
        base_addr   = 12'd100;
        num_blocks  = 16'd3;
        line_stride = '0;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (30) @(posedge clock);
        #1;
        ok = 0;
        for (int k = 0; k < N; k++)
            if (arr[k / D][k % D] === 32'(100 + k)) ok++;
        check_eq("pre_reset_words", ok, 29);
        reset_n = 1'b0;
        #1;
        check_eq("abort_valid", output_valid, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_rd_en", mem_rd_en, 0);
        check_eq("abort_addr", mem_addr, 0);
        nz = 0;
        for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++)
                if (arr[r][c] !== 32'd0) nz++;
        check_eq("abort_array_nonzero", nz, 0);
        @(negedge clock) reset_n = 1'b1;
        @(negedge clock);

        // Block-linear, two blocks, consumer always ready.
        run_cmd(0, 0, 2, 0, 0, 0, 1'b0);
        check_eq("lin_b1_first", arr[0][0], 64);
        check_eq("lin_b1_last", arr[D-1][D-1], 127);

        // Raster, one block.
        run_cmd(1, 16, 1, 64, 0, 0, 1'b0);
        check_eq("raster_last", arr[D-1][D-1], 471);

        // Backpressure: 20-cycle stall on each block.
        run_cmd(0, 512, 2, 0, 20, 20, 1'b0);

        // Address wrap at the top of memory.
        run_cmd(0, 4090, 1, 0, 0, 0, 1'b0);
        check_eq("wrap_word0", arr[0][6], 0);

        // Zero-length command.
        @(negedge clock);
        rd_log.delete();
        nz           = done_cnt;
        start        = 1'b1;
        num_blocks   = '0;
        @(posedge clock); #1;
        start = 1'b0;
        check_eq("zero_done", done, 1);
        check_eq("zero_busy", busy, 0);
        repeat (3) @(posedge clock);
        #1;
        check_eq("zero_done_once", done_cnt - nz, 1);
        check_eq("zero_reads", rd_log.size(), 0);

        // Start while busy is ignored.
        run_cmd(1, 300, 1, 40, 0, 3, 1'b1);

        // Randomized runs over random memory.
        fill_random();
        for (int t = 0; t < 6; t++) begin
            @(negedge clock);
            run_cmd($urandom_range(1, 0), $urandom_range(MEMSZ - 1, 0), $urandom_range(3, 1),
                    $urandom_range(300, 0), 0, 4, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
